// File: rtl/led_trail_pwm_pkg.sv
// Shared constants and helpers for the LED trail generator.
package led_trail_pwm_pkg;

    localparam logic MODE_WRAP   = 1'b0;
    localparam logic MODE_BOUNCE = 1'b1;

    // Head travel direction, only meaningful in bounce mode.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int n);
        int r = 0;
        int v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_trail_pwm_if.sv
// Control and LED-drive bundle of the trail generator.
interface led_trail_pwm_if
    import led_trail_pwm_pkg::*;
#(
    parameter int NUM_LEDS = 4,
    parameter int POS_W    = idx_width(NUM_LEDS)
);
    logic                en;
    logic                mode;
    logic [NUM_LEDS-1:0] leds;
    logic [POS_W-1:0]    pos;
    logic                step;

    modport master (output en, mode, input leds, pos, step);
    modport slave  (input en, mode, output leds, pos, step);
endinterface

// File: rtl/led_trail_pwm_channel.sv
// One PWM output: registered compare of brightness against the shared ramp.
module led_pwm_channel #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [PWM_BITS-1:0] b,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led
);

    // LED is on while the brightness exceeds the ramp; reset forces it dark at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) led <= 1'b0;
        else         led <= (b > pwm_cnt);
    end

endmodule

// File: rtl/led_trail_pwm.sv
// LED chaser: a head walks across NUM_LEDS outputs leaving a geometrically fading tail.
module led_trail_pwm
    import led_trail_pwm_pkg::*;
#(
    parameter int NUM_LEDS    = 4,
    parameter int STEP_DIV    = 2500000,
    parameter int PWM_BITS    = 4,
    parameter int DECAY_SHIFT = 1
) (
    input  logic           clk,
    input  logic           resetn,
    led_trail_pwm_if.slave bus
);

    localparam int POS_W = idx_width(NUM_LEDS);
    localparam int PRE_W = idx_width(STEP_DIV);

    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0]    LAST_POS = POS_W'(NUM_LEDS - 1);
    localparam logic [PWM_BITS-1:0] B_MAX    = '1;
    // Ramp stops one short of MAX so that MAX means "always on".
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [PRE_W-1:0]                   presc;
    logic [PWM_BITS-1:0]                pwm_cnt;
    logic [POS_W-1:0]                   pos_q, pos_nxt;
    dir_e                               dir_q, dir_nxt;
    logic [NUM_LEDS-1:0][PWM_BITS-1:0]  b_q, b_nxt;
    logic                               step_q;
    logic                               tick;
    logic [NUM_LEDS-1:0]                leds_w;

    // The step fires on the edge that leaves the last prescaler count.
    assign tick = bus.en && (presc == PRE_LAST);

    // Step prescaler; holds its count while frozen so a resume finishes the period.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     presc <= '0;
        else if (bus.en) presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
    end

    // Free-running PWM ramp, independent of en so a frozen trail keeps glowing.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pwm_cnt <= '0;
        else         pwm_cnt <= (pwm_cnt >= PWM_LAST) ? '0 : pwm_cnt + 1'b1;
    end

    // Trail state register: head, direction, brightness and the step strobe.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pos_q  <= '0;
            dir_q  <= DIR_UP;
            b_q    <= '0;
            b_q[0] <= B_MAX;
            step_q <= 1'b0;
        end else begin
            pos_q  <= pos_nxt;
            dir_q  <= dir_nxt;
            b_q    <= b_nxt;
            step_q <= tick;
        end
    end

    // Head movement and decay; mode is only looked at on a step.
    always_comb begin
        pos_nxt = pos_q;
        dir_nxt = dir_q;
        b_nxt   = b_q;
        if (tick) begin
            if (NUM_LEDS == 1) begin
                pos_nxt = '0;
                dir_nxt = DIR_UP;
            end else if (bus.mode == MODE_WRAP) begin
                // Wrap always travels upward, even if we were bouncing down.
                dir_nxt = DIR_UP;
                pos_nxt = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
            end else if (dir_q == DIR_UP) begin
                if (pos_q == LAST_POS) begin
                    dir_nxt = DIR_DOWN;
                    pos_nxt = LAST_POS - 1'b1;
                end else begin
                    pos_nxt = pos_q + 1'b1;
                end
            end else begin
                if (pos_q == '0) begin
                    dir_nxt = DIR_UP;
                    pos_nxt = POS_W'(1);
                end else begin
                    pos_nxt = pos_q - 1'b1;
                end
            end
            // New head is lit fully; everything else dims.
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (pos_nxt == POS_W'(i)) b_nxt[i] = B_MAX;
                else                      b_nxt[i] = b_q[i] >> DECAY_SHIFT;
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
            .clk     (clk),
            .resetn  (resetn),
            .b       (b_q[g]),
            .pwm_cnt (pwm_cnt),
            .led     (leds_w[g])
        );
    end

    assign bus.leds = leds_w;
    assign bus.pos  = pos_q;
    assign bus.step = step_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: step table, freeze/reset sequences, random run against a model.
module tb_led_trail_pwm;
    import led_trail_pwm_pkg::*;

    localparam int N    = 4;
    localparam int SD   = 4;
    localparam int PB   = 2;
    localparam int DS   = 1;
    localparam int MAXV = 3;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    led_trail_pwm_if #(.NUM_LEDS(N)) bus ();
    led_trail_pwm_if #(.NUM_LEDS(1)) bus1 ();
    assign bus1.en   = bus.en;
    assign bus1.mode = bus.mode;

    led_trail_pwm #(.NUM_LEDS(N), .STEP_DIV(SD), .PWM_BITS(PB), .DECAY_SHIFT(DS)) u0 (
        .clk(clk), .resetn(resetn), .bus(bus)
    );
    led_trail_pwm #(.NUM_LEDS(1), .STEP_DIV(SD), .PWM_BITS(PB), .DECAY_SHIFT(DS)) u1 (
        .clk(clk), .resetn(resetn), .bus(bus1)
    );

    int errors = 0;
    int checks = 0;
    bit chk_on = 0;

    // Reference model: trail as plain integers, stepping counted in enabled cycles.
    int       m_b[N];
    int       m_pos, m_dir, m_ecnt, m_edges;
    logic     m_step;
    logic [N-1:0] m_leds;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_b[i] = 0;
        m_b[0] = MAXV;
        m_pos = 0; m_dir = 1; m_ecnt = 0; m_edges = 0;
        m_step = 0; m_leds = '0;
    endtask

    task automatic model_edge();
        for (int i = 0; i < N; i++) m_leds[i] = (m_b[i] > (m_edges % MAXV));
        m_edges++;
        m_step = 0;
        if (bus.en) begin
            m_ecnt++;
            if (m_ecnt % SD == 0) begin
                m_step = 1;
                if (bus.mode == MODE_WRAP) begin
                    m_dir = 1;
                    m_pos = (m_pos + 1) % N;
                end else begin
                    if (m_pos + m_dir < 0 || m_pos + m_dir > N - 1) m_dir = -m_dir;
                    m_pos = m_pos + m_dir;
                end
                for (int i = 0; i < N; i++) m_b[i] = m_b[i] >> DS;
                m_b[m_pos] = MAXV;
            end
        end
    endtask

    // One clock: advance model, then compare just after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (chk_on) begin
            chk("m_leds", 32'(bus.leds), 32'(m_leds));
            chk("m_pos",  32'(bus.pos),  32'(m_pos));
            chk("m_step", 32'(bus.step), 32'(m_step));
        end
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.step && n < 16);
        if (!bus.step) chk("step_timeout", 32'(bus.step), 32'd1);
    endtask

    typedef struct packed {
        logic       mode;
        logic [1:0] pos;
        logic [7:0] b;     // {b3,b2,b1,b0}, two bits each
    } vec_t;

    vec_t tbl[16];
    int   on[N];
    int   n;
    logic [1:0] p0;

    initial begin
        tbl[0]  = '{1'b0, 2'd1, 8'b00_00_11_01};
        tbl[1]  = '{1'b0, 2'd2, 8'b00_11_01_00};
        tbl[2]  = '{1'b0, 2'd3, 8'b11_01_00_00};
        tbl[3]  = '{1'b0, 2'd0, 8'b01_00_00_11};
        tbl[4]  = '{1'b0, 2'd1, 8'b00_00_11_01};
        tbl[5]  = '{1'b1, 2'd2, 8'b00_11_01_00};
        tbl[6]  = '{1'b1, 2'd3, 8'b11_01_00_00};
        tbl[7]  = '{1'b1, 2'd2, 8'b01_11_00_00};
        tbl[8]  = '{1'b1, 2'd1, 8'b00_01_11_00};
        tbl[9]  = '{1'b1, 2'd0, 8'b00_00_01_11};
        tbl[10] = '{1'b1, 2'd1, 8'b00_00_11_01};
        tbl[11] = '{1'b1, 2'd2, 8'b00_11_01_00};
        tbl[12] = '{1'b1, 2'd3, 8'b11_01_00_00};
        tbl[13] = '{1'b1, 2'd2, 8'b01_11_00_00};
        tbl[14] = '{1'b0, 2'd3, 8'b11_01_00_00};  // wrap from bounce-down continues up
        tbl[15] = '{1'b0, 2'd0, 8'b01_00_00_11};

        resetn   = 1'b0;
        bus.en   = 1'b0;
        bus.mode = 1'b0;
        #1;
        chk("rst_leds", 32'(bus.leds), 32'd0);
        chk("rst_pos",  32'(bus.pos),  32'd0);
        chk("rst_step", 32'(bus.step), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        resetn = 1'b1;
        bus.en = 1'b1;
        chk_on = 1;

        // Step table: interval, head position and per-LED duty over one PWM period.
        for (int k = 0; k < 16; k++) begin
            bus.mode = tbl[k].mode;
            wait_step(n);
            chk("interval", 32'(n), (k == 0) ? 32'd4 : 32'd1);
            chk("tbl_pos", 32'(bus.pos), 32'(tbl[k].pos));
            for (int i = 0; i < N; i++) on[i] = 0;
            for (int c = 0; c < 3; c++) begin
                tick();
                chk("step_width", 32'(bus.step), 32'd0);
                for (int i = 0; i < N; i++) on[i] += int'(bus.leds[i]);
            end
            for (int i = 0; i < N; i++) chk("tbl_b", 32'(on[i]), 32'(tbl[k].b[2*i +: 2]));
        end

        // Freeze one cycle into a period; resume should finish only the remainder.
        wait_step(n);
        chk("pre_freeze", 32'(n), 32'd1);
        tick();
        p0 = bus.pos;
        bus.en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("frz_step", 32'(bus.step), 32'd0);
            chk("frz_pos",  32'(bus.pos),  32'(p0));
        end
        bus.en = 1'b1;
        wait_step(n);
        chk("resume_gap", 32'(n), 32'(SD - 1));

        // Random enable/mode traffic against the model.
        for (int c = 0; c < 400; c++) begin
            bus.en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
            tick();
        end

        // Asynchronous reset mid-run, checked before any clock edge.
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_leds", 32'(bus.leds), 32'd0);
        chk("arst_pos",  32'(bus.pos),  32'd0);
        chk("arst_step", 32'(bus.step), 32'd0);
        chk_on = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        resetn   = 1'b1;
        bus.en   = 1'b1;
        bus.mode = 1'b0;
        chk_on   = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rel_leds", 32'(bus.leds), 32'b0001);
        end

        // Single-LED instance: head pinned at 0 and always lit.
        for (int md = 0; md < 2; md++) begin
            bus.mode = md[0];
            for (int c = 0; c < 10; c++) begin
                tick();
                chk("one_leds", 32'(bus1.leds), 32'd1);
                chk("one_pos",  32'(bus1.pos),  32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
